// File: rtl/divider_controller.sv
`timescale 1ns/1ps
// Control FSM for the nBit restoring divider datapath: sequences clear, load and
// nBit shift/test iterations and drives the datapath's 15-bit ctrlWord.
module divider_controller #(
  parameter int nBit = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          b_zero,
  input  logic                          msbSub,
  input  logic                          msbCtr,
  output logic [14:0]                   ctrlWord,
  output logic                          busy,
  output logic                          done,
  output logic                          div_by_zero,
  output logic [2:0]                    dbg_state,
  output logic [$clog2(nBit+1)-1:0]     dbg_iter
);

  localparam int IterW = $clog2(nBit + 1);

  localparam int A_CLR    = 0;
  localparam int A_SL     = 1;
  localparam int A_LOAD   = 2;
  localparam int B_CLR    = 3;
  localparam int B_LOAD   = 4;
  localparam int R_CLR    = 5;
  localparam int R_SL     = 6;
  localparam int R_LOAD   = 7;
  localparam int Q_CLR    = 8;
  localparam int Q_SL     = 9;
  localparam int Q_SHIFTIN = 11;
  localparam int C_CLR    = 12;
  localparam int C_SL     = 13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_TEST  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               dz_q, dz_d;
  logic [IterW-1:0]   iter_q, iter_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dz_q    <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      dz_q    <= dz_d;
      iter_q  <= iter_d;
    end
  end

  // Handshake: start is accepted only in IDLE (no queuing); busy covers CLEAR
  // through the last TEST; done is a one-cycle pulse in which Q/R are valid.
  always_comb begin
    state_d     = state_q;
    dz_d        = dz_q;
    iter_d      = iter_q;
    ctrlWord    = '0;
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dz_d    = b_zero;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        ctrlWord[A_CLR] = 1'b1;
        ctrlWord[B_CLR] = 1'b1;
        ctrlWord[R_CLR] = 1'b1;
        ctrlWord[Q_CLR] = 1'b1;
        ctrlWord[C_CLR] = 1'b1;
        busy            = 1'b1;
        iter_d          = '0;
        // A zero divisor skips the datapath entirely; the clear leaves Q=R=0.
        state_d         = dz_q ? S_DONE : S_LOAD;
      end

      S_LOAD: begin
        ctrlWord[A_LOAD] = 1'b1;
        ctrlWord[B_LOAD] = 1'b1;
        busy             = 1'b1;
        state_d          = S_SHIFT;
      end

      S_SHIFT: begin
        ctrlWord[A_SL] = 1'b1;
        ctrlWord[R_SL] = 1'b1;
        ctrlWord[C_SL] = 1'b1;
        busy           = 1'b1;
        iter_d         = iter_q + {{(IterW-1){1'b0}}, 1'b1};
        state_d        = S_TEST;
      end

      S_TEST: begin
        // R >= B: commit the subtraction and shift a 1 into Q.
        ctrlWord[Q_SL]      = 1'b1;
        ctrlWord[Q_SHIFTIN] = ~msbSub;
        ctrlWord[R_LOAD]    = ~msbSub;
        busy                = 1'b1;
        state_d             = msbCtr ? S_DONE : S_SHIFT;
      end

      S_DONE: begin
        done        = 1'b1;
        div_by_zero = dz_q;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dbg_state = state_q;
  assign dbg_iter  = iter_q;

endmodule

// File: tb/tb_divider_controller.sv
`timescale 1ns/1ps
// Bench for divider_controller: drives a behavioural datapath from ctrlWord and
// checks every cycle against a sequence derived from plain division arithmetic.
module tb_divider_controller;

  localparam int NBIT = 8;
  localparam int EW   = 18;  // {busy, done, div_by_zero, ctrlWord}

  localparam logic [14:0] W_CLEAR = 15'((1 << 0) | (1 << 3) | (1 << 5) | (1 << 8) | (1 << 12));
  localparam logic [14:0] W_LOAD  = 15'((1 << 2) | (1 << 4));
  localparam logic [14:0] W_SHIFT = 15'((1 << 1) | (1 << 6) | (1 << 13));
  localparam logic [14:0] W_TEST0 = 15'(1 << 9);
  localparam logic [14:0] W_TEST1 = 15'((1 << 9) | (1 << 7) | (1 << 11));

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        b_zero = 1'b0;
  logic        msbSub, msbCtr;
  logic [14:0] ctrlWord;
  logic        busy, done, div_by_zero;
  logic [2:0]  dbg_state;
  logic [3:0]  dbg_iter;

  divider_controller #(.nBit(NBIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .b_zero      (b_zero),
    .msbSub      (msbSub),
    .msbCtr      (msbCtr),
    .ctrlWord    (ctrlWord),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state),
    .dbg_iter    (dbg_iter)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural datapath ----------------
  logic [7:0] a_in = '0, b_in = '0;
  logic [7:0] dp_a, dp_b, dp_r, dp_q, dp_c, dp_diff;

  assign dp_diff = dp_r - dp_b;
  assign msbSub  = dp_diff[7];
  assign msbCtr  = dp_c[7];

  always @(posedge clk) begin
    if (ctrlWord[0]) dp_a <= '0;
    else if (ctrlWord[2]) dp_a <= a_in;
    else if (ctrlWord[1]) dp_a <= {dp_a[6:0], 1'b0};

    if (ctrlWord[3]) dp_b <= '0;
    else if (ctrlWord[4]) dp_b <= b_in;

    if (ctrlWord[5]) dp_r <= '0;
    else if (ctrlWord[7]) dp_r <= dp_diff;
    else if (ctrlWord[6]) dp_r <= {dp_r[6:0], dp_a[7]};

    if (ctrlWord[8]) dp_q <= '0;
    else if (ctrlWord[9]) dp_q <= {dp_q[6:0], ctrlWord[11]};

    if (ctrlWord[12]) dp_c <= '0;
    else if (ctrlWord[13]) dp_c <= {dp_c[6:0], 1'b1};
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [EW-1:0] exp_q[$];
  logic [16:0]   res_q[$];   // {dz, quotient, remainder}
  int            done_cycs[$];

  // Expected cycle sequence from the division itself: quotient bit i (MSB first)
  // is exactly the TEST decision of iteration i.
  task automatic push_seq(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q, r;
    if (b == 0) begin
      exp_q.push_back({3'b100, W_CLEAR});
      exp_q.push_back({3'b011, 15'd0});
      res_q.push_back({1'b1, 8'd0, 8'd0});
    end else begin
      q = a / b;
      r = a % b;
      exp_q.push_back({3'b100, W_CLEAR});
      exp_q.push_back({3'b100, W_LOAD});
      for (int i = 0; i < NBIT; i++) begin
        exp_q.push_back({3'b100, W_SHIFT});
        exp_q.push_back({3'b100, q[NBIT-1-i] ? W_TEST1 : W_TEST0});
      end
      exp_q.push_back({3'b010, 15'd0});
      res_q.push_back({1'b0, q, r});
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    logic [16:0]   res;
    int            shifts;
    int            clear_cyc;
    if (rst_n) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("cycle", {busy, done, div_by_zero, ctrlWord}, e);
      if (ctrlWord[0]) begin
        clear_cyc = cyc;
        shifts    = 0;
      end
      if (ctrlWord[13]) shifts++;
      if (done) begin
        if (res_q.size() > 0) begin
          res = res_q.pop_front();
          check("quotient", dp_q, res[15:8]);
          check("remainder", dp_r, res[7:0]);
          check("div_by_zero", div_by_zero, res[16]);
          check("shift_count", shifts, res[16] ? 0 : NBIT);
          check("iter_count", dbg_iter, res[16] ? 0 : NBIT);
          check("latency", cyc - clear_cyc, res[16] ? 1 : 2 + 2 * NBIT);
        end else begin
          check("unexpected_done", 1, 0);
        end
        done_cycs.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_div(input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #2;
    a_in   = a;
    b_in   = b;
    b_zero = (b == 0);
    start  = 1'b1;
    exp_q.push_back('0);
    push_seq(a, b);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() > 0) && (t < 300)) begin
      @(posedge clk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b);
    start_div(a, b);
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    logic [7:0] ra, rb;

    #3;
    check("rst_ctrl", ctrlWord, 0);
    check("rst_flags", {busy, done, div_by_zero}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    run_div(8'd100, 8'd7);
    run_div(8'd7, 8'd100);
    run_div(8'd255, 8'd128);
    run_div(8'd123, 8'd0);

    // start pulsed mid-divide must be ignored
    n0 = done_cycs.size();
    start_div(8'd200, 8'd9);
    repeat (3) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_drain();
    repeat (2) @(posedge clk);
    check("single_done", done_cycs.size() - n0, 1);

    // start held for 40 cycles: two divides, one IDLE cycle apart
    n0 = done_cycs.size();
    @(posedge clk); #2;
    a_in = 8'd77; b_in = 8'd5; b_zero = 1'b0; start = 1'b1;
    exp_q.push_back('0);
    push_seq(8'd77, 8'd5);
    exp_q.push_back('0);
    push_seq(8'd250, 8'd3);
    repeat (5) @(posedge clk);
    #2 a_in = 8'd250; b_in = 8'd3;
    repeat (35) @(posedge clk);
    #2 start = 1'b0;
    wait_drain();
    repeat (2) @(posedge clk);
    check("held_done_count", done_cycs.size() - n0, 2);
    if (done_cycs.size() - n0 == 2)
      check("held_done_gap", done_cycs[n0+1] - done_cycs[n0], 20);

    // asynchronous reset in the 4th TEST cycle
    start_div(8'd99, 8'd4);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", ctrlWord, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", {done, div_by_zero}, 0);
    exp_q.delete();
    res_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_div(8'd50, 8'd6);

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 128));
      run_div(ra, rb);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divider_controller.md
Name: divider_controller

Overview:
- Control unit for the nBit restoring divider datapath; it sits directly upstream of the datapath and drives its 15-bit ctrlWord.
- Sequences clear, load, and nBit shift/test iterations, consuming the datapath status bits msbSub and msbCtr.
- Provides a start/busy/done handshake to the surrounding system and flags divide-by-zero.

Parameters:
- nBit, 8, operand width of the attached datapath; sets the iteration count and latency.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a divide; sampled only in IDLE
- b_zero  input  1  high when the divisor B on the datapath input is 0; sampled with start
- msbSub  input  1  MSB of datapath (R - B); 0 means R >= B
- msbCtr  input  1  MSB of datapath iteration counter
- ctrlWord  output  15  datapath control, bit map below
- busy  output  1  high while a divide is in progress
- done  output  1  one-cycle pulse; datapath Q/R valid in this cycle
- div_by_zero  output  1  high with done when the divisor was 0

Behaviour:
- Reset is one clock, clk; rst_n is asynchronous and active-low.
- ctrlWord bit map:
  - [0] A clr, [1] A sl, [2] A load
  - [3] B clr, [4] B load
  - [5] R clr, [6] R sl, [7] R load
  - [8] Q clr, [9] Q sl, [10] Q load, [11] Q shiftIn
  - [12] Ctr clr, [13] Ctr sl, [14] Ctr load
  - Bits 10 and 14 are never asserted.
- States: IDLE, CLEAR, LOAD, SHIFT, TEST, DONE. The state register is reset to IDLE.
- Output decode is Moore, except bits 7 and 11 in TEST, which depend on msbSub. Any bit not listed for a state is 0.
  - IDLE: ctrlWord=0, busy=0. If start, register dz=b_zero and go to CLEAR; otherwise stay.
  - CLEAR: bits 0,3,5,8,12 = 1; busy=1. If dz, go to DONE; else go to LOAD.
  - LOAD: bits 2,4 = 1; busy=1. Go to SHIFT.
  - SHIFT: bits 1,6,13 = 1; busy=1. A shifts left, R shifts left taking A's MSB, counter shifts in a 1. Go to TEST.
  - TEST: bit 9 = 1; bit 11 = ~msbSub; bit 7 = ~msbSub; busy=1.
    - If msbCtr=1, go to DONE; else go to SHIFT.
    - msbCtr rises after the nBit-th SHIFT, so exactly nBit iterations run.
  - DONE: ctrlWord=0, busy=0, done=1, div_by_zero=dz. Go to IDLE.
- Latency:
  - start sampled at edge k gives done high in cycle k+3+2*nBit (nBit=8: 19 cycles).
  - In the divide-by-zero case, done is high in cycle k+2.
- Results:
  - Q/R remain valid after DONE until the next CLEAR, because ctrlWord=0 holds all datapath registers.
  - On divide-by-zero, Q=R=0.
- Start handling:
  - start is ignored outside IDLE; no queuing.
  - start held continuously yields back-to-back divides with one IDLE cycle between them.
- Reset: asserting rst_n low in any state forces state=IDLE immediately.
  - ctrlWord=0, busy=0, done=0, div_by_zero=0 while reset is asserted.
  - dz is cleared.
  - Datapath contents are don't-care; the next CLEAR scrubs them.
- Operating range:
  - Results are correct for any dividend and for 1 <= B <= 2^(nBit-1), the range in which the msbSub sign test is exact.
  - Larger B gives undefined Q/R but the same handshake and timing.
- Outputs: busy, done, and div_by_zero are decoded from state (plus registered dz), so they are glitch-free relative to clk.

Test Plan:
- nBit=8, A=100, B=7, start one cycle → busy for 18 cycles, done pulse 19 cycles after start, Q=14, R=2, div_by_zero=0.
- A=7, B=100 → Q=0, R=7. During every TEST cycle, ctrlWord[11]=0 and ctrlWord[7]=0.
- A=255, B=128 → Q=1, R=127. Exactly 8 SHIFT cycles, counted via ctrlWord[13].
- B=0 (b_zero=1), start → CLEAR then DONE. done and div_by_zero high 2 cycles after start, Q=0, R=0, no LOAD cycle.
- start pulsed again in cycle 5 of a divide → ignored, single done. start held high for 40 cycles → two completed divides, done pulses 20 cycles apart.
- rst_n low asynchronously in the 4th TEST cycle → ctrlWord=0, busy=0 before the next clk edge. After release, A=50, B=6 → Q=8, R=2.
